// File: rtl/gray_frame_writer.sv
// rtl/gray_frame_writer.sv - buffers grayscale pixels and writes them to frame memory at sequential addresses
// Build macro GRAY_THRESH_EN binarises each written pixel against THRESH.
module gray_frame_writer #(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int THRESH     = 128
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 gw_enable,
  input  logic [7:0]                           din,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  output logic                                 mem_wr_en,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [7:0]                           mem_wdata,
  input  logic                                 mem_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] row,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] col,
  output logic                                 gw_done
);

  localparam int TOTAL = N * M;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(M - 1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic [7:0]       head, pix_out;
  logic [CNT_W-1:0] accepted, written;
  logic             push, pop, clear;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign mem_addr   = BASE_C + ADDR_W'(written);

`ifdef GRAY_THRESH_EN
  localparam logic [7:0] THRESH_C = 8'(THRESH);
  assign pix_out = (head >= THRESH_C) ? 8'hFF : 8'h00;
`else
  assign pix_out = head;
`endif

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    mem_wr_en = 1'b0;
    gw_done   = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        clear = 1'b1;
        if (gw_enable) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        din_ready = gw_enable && !fifo_full && (accepted < TOTAL_C);
        mem_wr_en = !fifo_empty;
        // A write presented during an abort still completes if memory takes it now.
        if (mem_wr_en && mem_ready && (written == LAST_C)) begin
          state_nxt = S_DONE;
        end else if (!gw_enable) begin
          state_nxt = S_IDLE;
          clear     = 1'b1;
        end
      end
      S_DONE: begin
        gw_done   = 1'b1;
        clear     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign push      = din_valid && din_ready;
  assign pop       = mem_wr_en && mem_ready;
  assign mem_wdata = mem_wr_en ? pix_out : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      accepted <= '0;
      written  <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        accepted <= '0;
        written  <= '0;
        row      <= '0;
        col      <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          accepted <= accepted + 1'b1;
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          written <= written + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule
